// File: rtl/vga_pio_pkg.sv
// Shared definitions for the VGA pixel-status PIO: register addresses and mode/state enums.
package vga_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_INPUT   = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE   = 3'd6;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

  typedef enum logic {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/vga_pio_edge_capture.sv
// Input synchroniser with history flop and sticky, write-1-to-clear edge capture bits.
module vga_pio_edge_capture
  import vga_pio_pkg::*;
#(
  parameter int IN_WIDTH  = 4,
  parameter int EDGE_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] in_port,
  input  logic [IN_WIDTH-1:0] clr,
  output logic [IN_WIDTH-1:0] in_sync2,
  output logic [IN_WIDTH-1:0] capture
);

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[1:0]);

  logic [IN_WIDTH-1:0] in_sync1;
  logic [IN_WIDTH-1:0] in_prev;
  logic [IN_WIDTH-1:0] edges;

  always_comb begin
    edges = '0;
    case (MODE)
      EDGE_RISE: edges = in_sync2 & ~in_prev;
      EDGE_FALL: edges = ~in_sync2 & in_prev;
      default:   edges = in_sync2 ^ in_prev;
    endcase
  end

  // Set is applied after the clear so a coincident edge is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_sync1 <= '0;
      in_sync2 <= '0;
      in_prev  <= '0;
      capture  <= '0;
    end else begin
      in_sync1 <= in_port;
      in_sync2 <= in_sync1;
      in_prev  <= in_sync2;
      capture  <= (capture & ~clr) | edges;
    end
  end

endmodule

// File: rtl/vga_pio_ctrl.sv
// Avalon-MM PIO for VGA pixel status: output register with set/clear/pulse, input edge irq.
module vga_pio_ctrl
  import vga_pio_pkg::*;
#(
  parameter int                   OUT_WIDTH    = 4,
  parameter int                   IN_WIDTH     = 4,
  parameter int                   EDGE_MODE    = 0,
  parameter int                   PULSE_CYCLES = 8,
  parameter logic [OUT_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic [OUT_WIDTH-1:0] out_port,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic                 irq
);

  localparam int              CNT_W    = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

  logic                 wr;
  logic [OUT_WIDTH-1:0] wd_out;
  logic [IN_WIDTH-1:0]  wd_in;
  logic [IN_WIDTH-1:0]  edge_clr;
  logic [IN_WIDTH-1:0]  in_sync2;
  logic [IN_WIDTH-1:0]  edge_capture;
  logic                 unused_wdata;

  logic [OUT_WIDTH-1:0] data_out;
  logic [IN_WIDTH-1:0]  irq_mask;
  logic [OUT_WIDTH-1:0] pulse_mask;
  logic [CNT_W-1:0]     pulse_cnt;
  pulse_state_e         pulse_state;

  assign wr           = chipselect & ~write_n;
  assign wd_out       = writedata[OUT_WIDTH-1:0];
  assign wd_in        = writedata[IN_WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign edge_clr     = (wr && address == ADDR_EDGE) ? wd_in : '0;
  assign out_port     = data_out | pulse_mask;

  vga_pio_edge_capture #(
    .IN_WIDTH  (IN_WIDTH),
    .EDGE_MODE (EDGE_MODE)
  ) u_edge (
    .clk      (clk),
    .reset    (reset),
    .in_port  (in_port),
    .clr      (edge_clr),
    .in_sync2 (in_sync2),
    .capture  (edge_capture)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(data_out);
      ADDR_INPUT:   readdata = 32'(in_sync2);
      ADDR_IRQMASK: readdata = 32'(irq_mask);
      ADDR_EDGE:    readdata = 32'(edge_capture);
      default:      readdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= RESET_VALUE;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr) begin
        case (address)
          ADDR_DATA:    data_out <= wd_out;
          ADDR_OUTSET:  data_out <= data_out | wd_out;
          ADDR_OUTCLR:  data_out <= data_out & ~wd_out;
          ADDR_IRQMASK: irq_mask <= wd_in;
          default:      ;
        endcase
      end
      irq <= |(edge_capture & irq_mask);
    end
  end

  // One shared counter; a new nonzero PULSE write restarts it and extends live bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_state <= PULSE_IDLE;
      pulse_mask  <= '0;
      pulse_cnt   <= '0;
    end else if (wr && address == ADDR_PULSE && wd_out != '0) begin
      pulse_state <= PULSE_ACTIVE;
      pulse_mask  <= pulse_mask | wd_out;
      pulse_cnt   <= CNT_LOAD;
    end else if (pulse_state == PULSE_ACTIVE) begin
      if (pulse_cnt == '0) begin
        pulse_state <= PULSE_IDLE;
        pulse_mask  <= '0;
      end else begin
        pulse_cnt <= pulse_cnt - CNT_W'(1);
      end
    end
  end

endmodule
